// File: rtl/eth_frame_fifo_if.sv
// eth_frame_fifo_if
// Groups the write-side, read-side and status signals of eth_frame_fifo.
//   master : the user side (drives wr_*, rd_en; observes read data and flags)
//   slave  : the FIFO side
// Write side : wr_en, wr_data, wr_last, wr_abort
// Read side  : rd_en, rd_data, rd_last, rd_valid
// Status     : full, empty, almost_full, level, frame_cnt, ovf_drop, udf
interface eth_frame_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_abort;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   frame_cnt;
    logic              ovf_drop;
    logic              udf;

    modport master (
        output wr_en, wr_data, wr_last, wr_abort, rd_en,
        input  rd_data, rd_last, rd_valid, full, empty, almost_full,
               level, frame_cnt, ovf_drop, udf
    );

    modport slave (
        input  wr_en, wr_data, wr_last, wr_abort, rd_en,
        output rd_data, rd_last, rd_valid, full, empty, almost_full,
               level, frame_cnt, ovf_drop, udf
    );
endinterface

// File: rtl/eth_frame_fifo.sv
// eth_frame_fifo
// Frame-aware store-and-forward FIFO. Words are written speculatively and
// become readable only once the frame's last word is accepted. The writer can
// abort a frame; a frame that overflows the buffer is dropped whole.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : eth_frame_fifo_if slave modport (write, read and status signals)
module eth_frame_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int AFULL_LVL = 56
) (
    input  logic             clk,
    input  logic             rst_n,
    eth_frame_fifo_if.slave  bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    wr_state_t state, next_state;

    logic [DATA_W:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, wr_cmt, rd_ptr;
    logic [PTR_W-1:0]  next_wr_ptr, next_wr_cmt;
    logic [PTR_W-1:0]  frame_cnt;
    logic [PTR_W-1:0]  level;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_last_q, rd_valid_q, ovf_drop_q, udf_q;
    logic              mem_we, commit, ovf;
    logic              full, empty, rd_accept;
    logic [DATA_W:0]   rd_word;

    // Flags come only from registered pointers; level counts uncommitted
    // words too so an open frame still consumes space.
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == PTR_W'(DEPTH));
    assign empty     = (rd_ptr == wr_cmt);
    assign rd_accept = bus.rd_en & ~empty;
    assign rd_word   = mem[rd_ptr[ADDR_W-1:0]];

    // Write state machine: decides whether the current word is stored,
    // committed, rolled back (abort) or discarded (overflow / drop mode).
    always_comb begin
        next_state  = state;
        next_wr_ptr = wr_ptr;
        next_wr_cmt = wr_cmt;
        mem_we      = 1'b0;
        commit      = 1'b0;
        ovf         = 1'b0;
        case (state)
            IDLE, WR: begin
                if (state == WR && bus.wr_abort) begin
                    next_wr_ptr = wr_cmt;
                    next_state  = IDLE;
                end else if (bus.wr_en && !bus.wr_abort) begin
                    if (full) begin
                        // Rewinding to wr_cmt throws away the whole open frame.
                        next_wr_ptr = wr_cmt;
                        ovf         = 1'b1;
                        next_state  = bus.wr_last ? IDLE : DROP;
                    end else begin
                        mem_we      = 1'b1;
                        next_wr_ptr = wr_ptr + PTR_W'(1);
                        if (bus.wr_last) begin
                            next_wr_cmt = wr_ptr + PTR_W'(1);
                            commit      = 1'b1;
                            next_state  = IDLE;
                        end else begin
                            next_state  = WR;
                        end
                    end
                end
            end
            DROP: begin
                if (bus.wr_abort || (bus.wr_en && bus.wr_last)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pointer, counter and registered read-port state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            rd_ptr     <= '0;
            frame_cnt  <= '0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            ovf_drop_q <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state      <= next_state;
            wr_ptr     <= next_wr_ptr;
            wr_cmt     <= next_wr_cmt;
            rd_valid_q <= rd_accept;
            ovf_drop_q <= ovf;
            udf_q      <= bus.rd_en & empty;
            if (rd_accept) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                rd_data_q <= rd_word[DATA_W-1:0];
                rd_last_q <= rd_word[DATA_W];
            end
            // A commit and an end-of-frame read in one cycle cancel out.
            if (commit && !(rd_accept && rd_word[DATA_W])) begin
                frame_cnt <= frame_cnt + PTR_W'(1);
            end else if (!commit && rd_accept && rd_word[DATA_W]) begin
                frame_cnt <= frame_cnt - PTR_W'(1);
            end
        end
    end

    // Storage array; no reset needed since empty/level gate every read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {bus.wr_last, bus.wr_data};
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (level >= PTR_W'(AFULL_LVL));
    assign bus.level       = level;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.ovf_drop    = ovf_drop_q;
    assign bus.udf         = udf_q;
endmodule

// File: tb/tb_eth_frame_fifo.sv
// tb_eth_frame_fifo
// Directed bench for eth_frame_fifo. Words of frames expected to survive are
// pushed into a scoreboard queue when written; a monitor pops and compares
// every rd_valid word. Flags are compared against hand-computed values.
module tb_eth_frame_fifo;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [8:0] exp_q [$];

    eth_frame_fifo_if #(.DATA_W(8), .ADDR_W(6)) bus ();

    eth_frame_fifo #(.DATA_W(8), .ADDR_W(6), .AFULL_LVL(56)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; every failure prints a FAIL line.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs, waits past the
    // rising edge to the next falling edge, then returns inputs to idle.
    task automatic applyStimulus(input logic we, input logic [7:0] d, input logic last,
                                 input logic abort, input logic re);
        bus.wr_en    = we;
        bus.wr_data  = d;
        bus.wr_last  = last;
        bus.wr_abort = abort;
        bus.rd_en    = re;
        @(negedge clk);
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.wr_last  = 1'b0;
        bus.wr_abort = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    // Write a word that is expected to be read back later.
    task automatic writeKept(input logic [7:0] d, input logic last, input logic re);
        exp_q.push_back({last, d});
        applyStimulus(1'b1, d, last, 1'b0, re);
    endtask

    // Monitor: compares each presented read word with the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rd_valid", 1, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                checkOutput("rd_data", int'(bus.rd_data), int'(e[7:0]));
                checkOutput("rd_last", int'(bus.rd_last), int'(e[8]));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 8'h00;
        bus.wr_last  = 1'b0;
        bus.wr_abort = 1'b0;
        bus.rd_en    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        checkOutput("rst_empty", int'(bus.empty), 1);
        checkOutput("rst_full", int'(bus.full), 0);
        checkOutput("rst_afull", int'(bus.almost_full), 0);
        checkOutput("rst_level", int'(bus.level), 0);
        checkOutput("rst_frame_cnt", int'(bus.frame_cnt), 0);
        checkOutput("rst_rd_valid", int'(bus.rd_valid), 0);
        checkOutput("rst_rd_data", int'(bus.rd_data), 0);
        checkOutput("rst_ovf", int'(bus.ovf_drop), 0);
        checkOutput("rst_udf", int'(bus.udf), 0);

        // Three-word frame: invisible until its last word is accepted
        writeKept(8'h11, 1'b0, 1'b0);
        checkOutput("f3_empty_w1", int'(bus.empty), 1);
        checkOutput("f3_level_w1", int'(bus.level), 1);
        writeKept(8'h22, 1'b0, 1'b0);
        checkOutput("f3_empty_w2", int'(bus.empty), 1);
        writeKept(8'h33, 1'b1, 1'b0);
        checkOutput("f3_empty_w3", int'(bus.empty), 0);
        checkOutput("f3_frame_cnt", int'(bus.frame_cnt), 1);
        checkOutput("f3_level", int'(bus.level), 3);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("f3_empty_after_rd", int'(bus.empty), 1);
        checkOutput("f3_frame_cnt_after_rd", int'(bus.frame_cnt), 0);
        checkOutput("f3_level_after_rd", int'(bus.level), 0);

        // Abort of a 4-word frame, then a 1-word frame
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("abort_level_before", int'(bus.level), 4);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_level", int'(bus.level), 0);
        checkOutput("abort_empty", int'(bus.empty), 1);
        writeKept(8'hAA, 1'b1, 1'b0);
        checkOutput("aa_frame_cnt", int'(bus.frame_cnt), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Overflow: 64 words fill the buffer, word 65 drops the frame
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_full", int'(bus.full), 1);
        checkOutput("ovf_level64", int'(bus.level), 64);
        checkOutput("ovf_afull", int'(bus.almost_full), 1);
        checkOutput("ovf_empty_uncommitted", int'(bus.empty), 1);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_pulse", int'(bus.ovf_drop), 1);
        checkOutput("ovf_level0", int'(bus.level), 0);
        checkOutput("ovf_full_clear", int'(bus.full), 0);
        applyStimulus(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_pulse_end", int'(bus.ovf_drop), 0);
        checkOutput("drop_level_a", int'(bus.level), 0);
        applyStimulus(1'b1, 8'hF2, 1'b1, 1'b0, 1'b0);
        checkOutput("drop_level_b", int'(bus.level), 0);
        checkOutput("drop_frame_cnt", int'(bus.frame_cnt), 0);
        writeKept(8'h5A, 1'b0, 1'b0);
        writeKept(8'h5B, 1'b1, 1'b0);
        checkOutput("post_drop_level", int'(bus.level), 2);
        checkOutput("post_drop_frame_cnt", int'(bus.frame_cnt), 1);
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Wrap and almost_full: 40-word frame, then a second 40-word frame
        for (int i = 0; i < 40; i++) writeKept(8'(i), (i == 39), 1'b0);
        checkOutput("wrap_level40", int'(bus.level), 40);
        checkOutput("wrap_afull40", int'(bus.almost_full), 0);
        for (int j = 0; j < 16; j++) begin
            writeKept(8'(8'h40 + j), 1'b0, 1'b0);
            if (j == 14) checkOutput("afull_at55", int'(bus.almost_full), 0);
        end
        checkOutput("afull_at56", int'(bus.almost_full), 1);
        checkOutput("level56", int'(bus.level), 56);
        for (int j = 16; j < 40; j++) writeKept(8'(8'h40 + j), (j == 39), 1'b1);
        checkOutput("conc_level", int'(bus.level), 56);
        checkOutput("conc_frame_cnt", int'(bus.frame_cnt), 2);
        repeat (16) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_frame_cnt1", int'(bus.frame_cnt), 1);
        checkOutput("wrap_level40b", int'(bus.level), 40);
        checkOutput("wrap_afull_clear", int'(bus.almost_full), 0);
        repeat (40) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_empty", int'(bus.empty), 1);
        checkOutput("wrap_frame_cnt0", int'(bus.frame_cnt), 0);

        // Underflow: read data holds the last word read (0x67, last)
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("udf_pulse", int'(bus.udf), 1);
        checkOutput("udf_rd_valid", int'(bus.rd_valid), 0);
        checkOutput("udf_rd_data_hold", int'(bus.rd_data), 8'h67);
        checkOutput("udf_rd_last_hold", int'(bus.rd_last), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("udf_pulse_end", int'(bus.udf), 0);

        // Commit and end-of-frame read in the same cycle
        writeKept(8'h01, 1'b1, 1'b0);
        checkOutput("same_cyc_cnt_before", int'(bus.frame_cnt), 1);
        writeKept(8'h02, 1'b1, 1'b1);
        checkOutput("same_cyc_frame_cnt", int'(bus.frame_cnt), 1);
        checkOutput("same_cyc_level", int'(bus.level), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("same_cyc_cnt_after", int'(bus.frame_cnt), 0);
        @(negedge clk);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/eth_frame_fifo.md
# eth_frame_fifo

Parametrised, frame-aware synchronous FIFO for the Ethernet bridge datapath, sitting between the port receive logic and the forwarding/transmit side. Words of a frame are written speculatively and become readable only when the frame's last word is accepted, giving store-and-forward behaviour. Frames can be aborted by the writer, and a frame that overflows the buffer is discarded whole. Unlike the first-generation byte FIFO, it supports simultaneous read and write, parametrised width and depth, an occupancy level, almost-full, and frame counting.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 6, log2 of depth; DEPTH = 2^ADDR_W words
- AFULL_LVL, 56, almost_full asserts when level >= AFULL_LVL (1..DEPTH)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- wr_last  in  1  wr_data is the last word of its frame
- wr_abort  in  1  discard the frame currently being written
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_last  out  1  registered end-of-frame marker for rd_data
- rd_valid  out  1  rd_data/rd_last updated this cycle
- full  out  1  level == DEPTH
- empty  out  1  no committed word readable
- almost_full  out  1  level >= AFULL_LVL
- level  out  ADDR_W+1  words stored, committed plus uncommitted
- frame_cnt  out  ADDR_W+1  complete frames stored and not yet fully read
- ovf_drop  out  1  one-cycle pulse: frame dropped on overflow
- udf  out  1  one-cycle pulse: rd_en while empty

## Operation
- Storage: DEPTH x (DATA_W+1) array holding data plus the last bit.
- Pointers are ADDR_W+1 bits wide with a wrap bit:
  - wr_ptr: speculative write pointer
  - wr_cmt: committed write pointer
  - rd_ptr: read pointer
- Flag and count definitions:
  - level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1)
  - full = (level == DEPTH)
  - empty = (rd_ptr == wr_cmt)
  - All flags derive from registered state only, with no combinational input-to-output paths.
- Write state machine:
  - IDLE (no frame open):
    - Accepted write (wr_en & !full & !wr_abort): store the word, wr_ptr += 1.
    - If wr_last is set: wr_cmt <= wr_ptr+1 and frame_cnt += 1; stay in IDLE.
    - Otherwise go to WR.
  - WR (frame open):
    - Accepted write stores the word.
    - An accepted write with wr_last commits as above and returns to IDLE.
  - WR, wr_abort: wr_ptr <= wr_cmt and return to IDLE. Any wr_en in the same cycle is ignored.
  - IDLE or WR, wr_en & full:
    - wr_ptr <= wr_cmt and pulse ovf_drop.
    - If wr_last is set, go to IDLE; otherwise go to DROP.
  - DROP: all writes are ignored.
    - wr_en & wr_last returns to IDLE with no commit.
    - wr_abort returns to IDLE.
  - wr_abort in IDLE has no effect.
- Read:
  - rd_en & !empty: next cycle rd_data/rd_last = mem[rd_ptr] and rd_valid = 1; rd_ptr += 1.
  - If the word read has last set: frame_cnt -= 1.
  - rd_en & empty: rd_valid = 0, rd_data/rd_last hold, and udf pulses.
- Simultaneous events:
  - Read and write in the same cycle are both performed.
  - Commit and last-word read in the same cycle leave frame_cnt unchanged.
  - A write that fills the last slot is accepted in the same cycle as a read.
  - full is evaluated on the pre-edge level, so a write in a full cycle drops the frame even if a read frees a slot that cycle.

## Timing
- Reset values: all pointers 0, state IDLE, rd_data 0, rd_last 0, rd_valid 0, full 0, empty 1, almost_full 0 (AFULL_LVL >= 1), level 0, frame_cnt 0, ovf_drop 0, udf 0.
- Reset mid-frame discards all contents, including the open frame.
- Read latency is 1 cycle: rd_en sampled at edge N gives data valid after edge N, with rd_valid high for that one cycle.
- Commit visibility: the last word accepted at edge N clears empty after edge N, so a read can be issued in cycle N+1.
- level, full, and almost_full update on the edge after the accepted write or read.
- An abort or drop reduces level on the same edge.
- Pointer wrap is natural modulo 2^(ADDR_W+1). DEPTH-word frames fit exactly.

## Test plan
- Reset, then one 3-word frame (0x11, 0x22, 0x33 with last): empty stays 1 until the edge after 0x33, then frame_cnt = 1. Three reads return 0x11, 0x22, 0x33 with rd_last = 1 on 0x33 only, then empty = 1 and frame_cnt = 0.
- Write 4 words, then assert wr_abort: level returns to 0 and empty stays 1. A following 1-word frame 0xAA reads back as 0xAA with rd_last = 1.
- With the FIFO empty, write 65 words with no last at default parameters:
  - full = 1 after word 64; word 65 pulses ovf_drop and level = 0.
  - Further words up to and including wr_last are ignored; the next frame is stored normally.
- Fill with a 40-word frame and read concurrently every cycle while writing a second frame: data order is preserved across pointer wrap; almost_full asserts exactly at level 56.
- rd_en on an empty FIFO: udf pulses 1 cycle, rd_valid = 0, rd_data unchanged.
- Single-word frame committed in the same cycle as the last word of the previous frame is read: frame_cnt stays 1.
